uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with an internal TX FIFO. It is the successor to the fixed 8-bit transmitter. It adds configurable data width, oversample ratio, one or two stop bits and buffered multi-byte transmission. It sits between the host-side valid/ready stream and the tx pin, and is paced by the oversample_tick from baud_gen.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..9.
FIFO_DEPTH, 16, TX FIFO entries; power of 2, minimum 2.
OVERSAMPLE, 16, oversample_ticks per bit period; minimum 4.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous reset, active-low (asserted when 0)
oversample_tick  input  1  one-clk strobe from baud_gen, at OVERSAMPLE x baud rate
in_valid  input  1  host word valid
in_ready  output  1  FIFO can accept a word
in_data  input  DATA_BITS  host word, LSB transmitted first
parity_en  input  1  1 = parity bit appended
parity_odd  input  1  1 = odd parity, 0 = even parity
two_stop  input  1  1 = two stop bits, 0 = one stop bit
tx  output  1  serial line, idles high
busy  output  1  frame in progress or FIFO non-empty
fifo_count  output  $clog2(FIFO_DEPTH)+1  words currently buffered

Behaviour:
- Reset (async, active-low): tx=1, busy=0, fifo_count=0, FSM=IDLE, FIFO pointers cleared. in_ready=0 while reset is asserted and 1 from the first clk after deassertion.
- Reset asserted mid-frame: tx returns to 1 immediately (asynchronously). The frame and all FIFO contents are discarded.
- Push: a word is written when in_valid && in_ready on a clk edge. in_ready = (fifo_count != FIFO_DEPTH). A push while full cannot occur. fifo_count updates on the clk edge after the push.
- Simultaneous push and pop: fifo_count is unchanged, and both operations take effect.
- FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP1 -> [STOP2] -> IDLE.
- IDLE -> START: on a clk where oversample_tick=1 and the FIFO is non-empty.
  - The head word is popped on that clk.
  - parity_en, parity_odd and two_stop are latched on that clk and hold for the whole frame.
  - Changing these inputs mid-frame has no effect on the current frame.
- Each state lasts exactly OVERSAMPLE oversample_ticks, counted by an internal tick counter that wraps from OVERSAMPLE-1 to 0.
- tx levels per state:
  - START: 0.
  - DATA: DATA_BITS bits, LSB first; the bit index advances at each bit boundary.
  - PARITY: present only if parity_en was latched as 1. Value is XOR(data) for even parity, ~XOR(data) for odd parity.
  - STOP1 and STOP2: 1. STOP2 is present only if two_stop was latched as 1.
- Back-to-back frames: at the end of the last stop bit, if the FIFO is non-empty, the FSM goes directly to START with no idle gap. Otherwise it goes to IDLE.
- tx is registered: it changes on the clk edge where the state or bit boundary occurs.
- busy = (FSM != IDLE) || (fifo_count != 0).
- Frame length in bit periods: 1 + DATA_BITS + parity_en + 1 + two_stop.
- oversample_tick is ignored while in IDLE with the FIFO empty.

Optional Feature:
Macro UART_TX_CTS_EN.
- Defined: adds port cts_n (input, 1, active-low clear-to-send, already synchronised by the caller).
  - IDLE -> START additionally requires cts_n=0.
  - A frame already started always completes, even if cts_n rises mid-frame.
  - A back-to-back start also requires cts_n=0; otherwise the FSM enters IDLE and waits.
- Not defined: no cts_n port; transmission starts regardless of flow control.

Test Plan:
- 50 MHz clk, baud_gen at 115200 (OVERSAMPLE=16, DATA_BITS=8). Push 0x41 with parity_en=1, parity_odd=0 -> tx sequence 0,1,0,0,0,0,0,1,0,0,1, each bit 16 ticks; busy falls after the stop bit; fifo_count returns to 0.
- Same word with parity_odd=1 and two_stop=1 -> parity bit 1, then two stop bits of 1; total frame 12 bit periods.
- Push 17 words (0x00..0x10) back-to-back while the line is idle -> in_ready=0 once fifo_count reaches 16. Word 0x10 is taken only after the first pop. All 17 frames go out contiguously with no idle gap, in order.
- DATA_BITS=7, parity_en=0, push 0x55 -> frame 0,1,0,1,0,1,0,1,1 (start, 7 data bits, stop), 9 bit periods.
- Assert reset mid-way through the DATA state of the second of three queued frames -> tx=1 immediately, fifo_count=0, busy=0. After release, in_ready=1 and no residual frame is sent.
- UART_TX_CTS_EN defined, cts_n=1, push 0xA5 -> tx stays 1 and busy=1. Drive cts_n=0 -> frame starts at the next oversample_tick. Raising cts_n mid-frame does not stop the frame.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo - UART transmitter with an internal TX FIFO.
//
// Host words enter through a valid/ready stream and are buffered in a
// FIFO_DEPTH-entry FIFO. A frame FSM pops the head word and serialises it
// onto tx. The frame is a start bit, DATA_BITS data bits (LSB first), an
// optional parity bit, and one or two stop bits. Each bit lasts OVERSAMPLE
// oversample_ticks from baud_gen.
//
// Optional feature macro: UART_TX_CTS_EN. When it is defined, the port
// cts_n is added and a new frame starts only while cts_n is 0.
//
// Ports:
//   clk              system clock
//   reset            asynchronous reset, active-low
//   oversample_tick  one-clk strobe at OVERSAMPLE x baud rate
//   in_valid         host word valid
//   in_ready         FIFO can accept a word
//   in_data          host word, LSB transmitted first
//   parity_en        1 = append parity bit (latched at frame start)
//   parity_odd       1 = odd parity, 0 = even (latched at frame start)
//   two_stop         1 = two stop bits (latched at frame start)
//   cts_n            active-low clear-to-send (only with UART_TX_CTS_EN)
//   tx               serial line, idles high
//   busy             frame in progress or FIFO non-empty
//   fifo_count       words currently buffered
module uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int OVERSAMPLE = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          oversample_tick,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_BITS-1:0]          in_data,
  input  logic                          parity_en,
  input  logic                          parity_odd,
  input  logic                          two_stop,
`ifdef UART_TX_CTS_EN
  input  logic                          cts_n,
`endif
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

  // FIFO storage and pointers. The pointers wrap naturally because
  // FIFO_DEPTH is a power of two.
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_reg;
  logic [AW-1:0]        rd_ptr_reg;
  logic [AW:0]          count_reg;
  logic                 ready_en_reg;  // holds in_ready low until the first clk after reset

  // Frame FSM state
  state_t               state_reg;
  logic [TW-1:0]        tick_cnt_reg;
  logic [BW-1:0]        bit_idx_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 parity_bit_reg;
  logic                 parity_en_reg;
  logic                 two_stop_reg;
  logic                 tx_reg;

  logic                 push;
  logic                 pop;
  logic                 fifo_empty;
  logic                 tick_last;
  logic                 frame_done;
  logic                 cts_ok;
  logic [DATA_BITS-1:0] head_word;

`ifdef UART_TX_CTS_EN
  assign cts_ok = ~cts_n;
`else
  assign cts_ok = 1'b1;
`endif

  assign fifo_empty = (count_reg == '0);
  assign in_ready   = ready_en_reg && (count_reg != (AW+1)'(FIFO_DEPTH));
  assign push       = in_valid && in_ready;
  assign head_word  = mem[rd_ptr_reg];
  assign tick_last  = (tick_cnt_reg == TW'(OVERSAMPLE - 1));

  // The last tick of the final stop bit. If another word is waiting,
  // the next start bit begins on this same tick, so there is no idle gap.
  assign frame_done = tick_last &&
                      (((state_reg == STOP1) && !two_stop_reg) || (state_reg == STOP2));

  // A frame starts (and pops the head word) from IDLE, or back-to-back at
  // the end of a frame.
  assign pop = oversample_tick && !fifo_empty && cts_ok &&
               ((state_reg == IDLE) || frame_done);

  assign tx         = tx_reg;
  assign busy       = (state_reg != IDLE) || !fifo_empty;
  assign fifo_count = count_reg;

  // FIFO RAM write port. It has no reset, so it can map onto memory.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      ready_en_reg <= 1'b0;
    end else begin
      ready_en_reg <= 1'b1;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      tick_cnt_reg   <= '0;
      bit_idx_reg    <= '0;
      shift_reg      <= '0;
      parity_bit_reg <= 1'b0;
      parity_en_reg  <= 1'b0;
      two_stop_reg   <= 1'b0;
      tx_reg         <= 1'b1;
    end else if (pop) begin
      // Latch the word and the frame format. The format then holds
      // for the whole frame.
      state_reg      <= START;
      tx_reg         <= 1'b0;
      tick_cnt_reg   <= '0;
      bit_idx_reg    <= '0;
      shift_reg      <= head_word;
      parity_bit_reg <= (^head_word) ^ parity_odd;
      parity_en_reg  <= parity_en;
      two_stop_reg   <= two_stop;
    end else if (oversample_tick && (state_reg != IDLE)) begin
      if (!tick_last) begin
        tick_cnt_reg <= tick_cnt_reg + 1'b1;
      end else begin
        tick_cnt_reg <= '0;
        case (state_reg)
          START: begin
            state_reg   <= DATA;
            tx_reg      <= shift_reg[0];
            shift_reg   <= shift_reg >> 1;
            bit_idx_reg <= '0;
          end
          DATA: begin
            if (bit_idx_reg == BW'(DATA_BITS - 1)) begin
              if (parity_en_reg) begin
                state_reg <= PARITY;
                tx_reg    <= parity_bit_reg;
              end else begin
                state_reg <= STOP1;
                tx_reg    <= 1'b1;
              end
            end else begin
              tx_reg      <= shift_reg[0];
              shift_reg   <= shift_reg >> 1;
              bit_idx_reg <= bit_idx_reg + 1'b1;
            end
          end
          PARITY: begin
            state_reg <= STOP1;
            tx_reg    <= 1'b1;
          end
          STOP1: begin
            state_reg <= two_stop_reg ? STOP2 : IDLE;
            tx_reg    <= 1'b1;
          end
          default: begin
            state_reg <= IDLE;
            tx_reg    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       tick_en;
  logic       in_valid, in_valid7;
  logic [7:0] in_data;
  logic [6:0] in_data7;
  logic       parity_en, parity_odd, two_stop;
  logic       in_ready, in_ready7;
  logic       tx, tx7, busy, busy7;
  logic [4:0] fifo_count, fifo_count7;
`ifdef UART_TX_CTS_EN
  logic       cts_n;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct { logic [11:0] bits; int len; } frame_t;
  typedef struct { logic [7:0] data; logic pen; logic podd; logic two; logic [11:0] bits; int len; } vec_t;

  frame_t sb[$];
  vec_t   vecs[5];

  always #5 clk = ~clk;

  uart_tx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(16), .OVERSAMPLE(16)) u_dut (
    .clk(clk), .reset(reset), .oversample_tick(tick),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .parity_en(parity_en), .parity_odd(parity_odd), .two_stop(two_stop),
`ifdef UART_TX_CTS_EN
    .cts_n(cts_n),
`endif
    .tx(tx), .busy(busy), .fifo_count(fifo_count)
  );

  uart_tx_fifo #(.DATA_BITS(7), .FIFO_DEPTH(16), .OVERSAMPLE(16)) u_dut7 (
    .clk(clk), .reset(reset), .oversample_tick(tick),
    .in_valid(in_valid7), .in_ready(in_ready7), .in_data(in_data7),
    .parity_en(parity_en), .parity_odd(parity_odd), .two_stop(two_stop),
`ifdef UART_TX_CTS_EN
    .cts_n(cts_n),
`endif
    .tx(tx7), .busy(busy7), .fifo_count(fifo_count7)
  );

  // Oversample strobe: one clk high every 4 clks, so one bit is 64 clks.
  initial begin
    int div;
    div  = 0;
    tick = 1'b0;
    forever begin
      @(negedge clk);
      tick = tick_en && (div == 3);
      div  = (div + 1) % 4;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic tx_of(input int sel);
    return (sel != 0) ? tx7 : tx;
  endfunction

  function automatic logic busy_of(input int sel);
    return (sel != 0) ? busy7 : busy;
  endfunction

  function automatic logic [4:0] count_of(input int sel);
    return (sel != 0) ? fifo_count7 : fifo_count;
  endfunction

  // Reference frame builder: transmission order, first bit ends up most significant.
  function automatic frame_t model(input logic [8:0] d, input int nb,
                                   input logic pen, input logic podd, input logic two);
    frame_t f;
    logic   par;
    f.bits = '0;
    f.len  = 0;
    par    = 1'b0;
    f.bits = {f.bits[10:0], 1'b0}; f.len++;
    for (int i = 0; i < nb; i++) begin
      f.bits = {f.bits[10:0], d[i]}; f.len++;
      par ^= d[i];
    end
    if (pen) begin f.bits = {f.bits[10:0], par ^ podd}; f.len++; end
    f.bits = {f.bits[10:0], 1'b1}; f.len++;
    if (two) begin f.bits = {f.bits[10:0], 1'b1}; f.len++; end
    return f;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // Offer one word and wait for it to be accepted. The expected frame
  // joins the scoreboard when the word is driven.
  task automatic push_word(input int sel, input logic [8:0] d, input frame_t f,
                           output logic [4:0] cnt_at_accept);
    int n;
    @(negedge clk);
    if (sel != 0) begin in_valid7 = 1'b1; in_data7 = d[6:0]; end
    else          begin in_valid  = 1'b1; in_data  = d[7:0]; end
    sb.push_back(f);
    n = 0;
    while (!((sel != 0) ? in_ready7 : in_ready) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    cnt_at_accept = count_of(sel);
    if (n >= 3000) chk("push_timeout", 32'd0, 32'd1);
    else @(negedge clk);
    in_valid  = 1'b0;
    in_valid7 = 1'b0;
  endtask

  // Sample n frames at mid-bit and compare them with the scoreboard.
  // After the first frame, each start bit must follow the previous stop
  // bit directly. With flip set, the format inputs are inverted during the
  // start bit, which must not affect the frame in flight.
  task automatic check_frames(input int sel, input int n, input bit flip);
    frame_t       e;
    logic [11:0]  got;
    int           w;
    for (int k = 0; k < n; k++) begin
      if (k == 0) begin
        w = 0;
        while (tx_of(sel) !== 1'b0 && w < 20000) begin @(negedge clk); w++; end
        if (w >= 20000) begin chk("start_timeout", 32'd0, 32'd1); return; end
        repeat (32) @(negedge clk);
      end
      if (sb.size() == 0) begin chk("scoreboard_empty", 32'd0, 32'd1); return; end
      e   = sb.pop_front();
      got = '0;
      for (int i = 0; i < e.len; i++) begin
        got = {got[10:0], tx_of(sel)};
        if (i == 0 && flip) begin
          parity_en  = ~parity_en;
          parity_odd = ~parity_odd;
          two_stop   = ~two_stop;
        end
        if (i < e.len - 1) repeat (64) @(negedge clk);
      end
      $display("frame dut%0d #%0d: got %b required %b (len %0d)", sel, k, got, e.bits, e.len);
      chk("frame_bits", {20'd0, got}, {20'd0, e.bits});
      chk("busy_last_bit", {31'd0, busy_of(sel)}, 32'd1);
      if (k < n - 1) begin
        repeat (64) @(negedge clk);
      end else begin
        repeat (40) @(negedge clk);
        chk("busy_after_frame", {31'd0, busy_of(sel)}, 32'd0);
        chk("count_after_frame", {27'd0, count_of(sel)}, 32'd0);
      end
    end
  endtask

  initial begin
    logic [4:0] cnt;
    frame_t     f;
    bit         saw_low;

    vecs[0] = '{8'h41, 1'b1, 1'b0, 1'b0, 12'b01000001001,  11};
    vecs[1] = '{8'h41, 1'b1, 1'b1, 1'b1, 12'b010000010111, 12};
    vecs[2] = '{8'hFF, 1'b0, 1'b0, 1'b0, 12'b0111111111,   10};
    vecs[3] = '{8'h00, 1'b1, 1'b1, 1'b1, 12'b000000000111, 12};
    vecs[4] = '{8'hA5, 1'b1, 1'b0, 1'b0, 12'b01010010101,  11};

    reset      = 1'b0;
    tick_en    = 1'b0;
    in_valid   = 1'b0; in_data  = '0;
    in_valid7  = 1'b0; in_data7 = '0;
    parity_en  = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
`ifdef UART_TX_CTS_EN
    cts_n      = 1'b0;
`endif

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_tx", {31'd0, tx}, 32'd1);
    chk("reset_tx7", {31'd0, tx7}, 32'd1);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_count", {27'd0, fifo_count}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
    reset = 1'b1;
    #1;
    chk("in_ready_before_clk", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    chk("in_ready_after_clk", {31'd0, in_ready}, 32'd1);

    // Table-driven single frames. The format inputs flip mid-frame.
    tick_en = 1'b1;
    for (int v = 0; v < 5; v++) begin
      parity_en  = vecs[v].pen;
      parity_odd = vecs[v].podd;
      two_stop   = vecs[v].two;
      f.bits = vecs[v].bits;
      f.len  = vecs[v].len;
      push_word(0, {1'b0, vecs[v].data}, f, cnt);
      check_frames(0, 1, 1'b1);
    end

    // 7-bit instance, no parity
    parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
    f.bits = 12'b010101011;
    f.len  = 9;
    push_word(1, 9'h055, f, cnt);
    check_frames(1, 1, 1'b0);

    // Fill the FIFO while the line is idle, then send 17 contiguous frames.
    tick_en = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 16; i++) push_word(0, 9'(i), model(9'(i), 8, 1'b0, 1'b0, 1'b0), cnt);
    @(negedge clk);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    chk("full_count", {27'd0, fifo_count}, 32'd16);
    chk("full_busy", {31'd0, busy}, 32'd1);
    chk("full_tx_idle", {31'd0, tx}, 32'd1);
    fork
      begin
        tick_en = 1'b1;
        push_word(0, 9'h010, model(9'h010, 8, 1'b0, 1'b0, 1'b0), cnt);
        chk("count_when_0x10_taken", {27'd0, cnt}, 32'd15);
      end
      check_frames(0, 17, 1'b0);
    join

    // Reset in the DATA bits of the second of three queued frames
    tick_en = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) push_word(0, 9'h0C3, model(9'h0C3, 8, 1'b0, 1'b0, 1'b0), cnt);
    tick_en = 1'b1;
    begin
      int w;
      w = 0;
      while (tx !== 1'b0 && w < 2000) begin @(negedge clk); w++; end
      chk("reset_test_start", {31'd0, (w < 2000)}, 32'd1);
    end
    repeat (640 + 3 * 64 + 32) @(negedge clk);
    chk("second_frame_busy", {31'd0, busy}, 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("midframe_reset_tx", {31'd0, tx}, 32'd1);
    chk("midframe_reset_count", {27'd0, fifo_count}, 32'd0);
    chk("midframe_reset_busy", {31'd0, busy}, 32'd0);
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_reset_in_ready", {31'd0, in_ready}, 32'd1);
    saw_low = 1'b0;
    repeat (2000) begin
      @(negedge clk);
      if (tx !== 1'b1) saw_low = 1'b1;
    end
    chk("no_residual_frame", {31'd0, saw_low}, 32'd0);
    chk("post_reset_busy", {31'd0, busy}, 32'd0);

`ifdef UART_TX_CTS_EN
    // Flow control: hold off, then release, then raise mid-frame.
    cts_n = 1'b1;
    parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
    f.bits = 12'b0101001011;
    f.len  = 10;
    push_word(0, 9'h0A5, f, cnt);
    repeat (500) @(negedge clk);
    chk("cts_hold_tx", {31'd0, tx}, 32'd1);
    chk("cts_hold_busy", {31'd0, busy}, 32'd1);
    chk("cts_hold_count", {27'd0, fifo_count}, 32'd1);
    fork
      begin
        cts_n = 1'b0;
        check_frames(0, 1, 1'b0);
      end
      begin
        repeat (300) @(negedge clk);
        cts_n = 1'b1;
      end
    join
    cts_n = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
